// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operating modes and burst FSM states.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift_mode(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: owns the FSM and the shift down-counter, tells the datapath
// when to shift and in which direction.
//
// state    | meaning
// ST_IDLE  | single-cycle ops allowed; a shift-mode start launches a burst
// ST_SHIFT | one shift per edge until the counter reaches terminal count
// ST_DONE  | one-cycle completion pulse, then back to idle
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  output logic             burst_shift,
  output logic             burst_left,
  output logic             idle_op,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             dir_left_q, dir_left_d;
  logic [LEN_W-1:0] len_clamped;
  mode_e            mode_m;
  logic             burst_req;

  assign mode_m      = mode_e'(mode);
  assign burst_req   = start && is_shift_mode(mode_m);
  assign len_clamped = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
  assign burst_left  = dir_left_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_left_d  = dir_left_q;
    burst_shift = 1'b0;
    idle_op     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (burst_req) begin
          dir_left_d = (mode_m == MODE_SHL);
          if (len_clamped == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = len_clamped;
            state_d = ST_SHIFT;
          end
        end else begin
          idle_op = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy        = 1'b1;
        burst_shift = 1'b1;
        cnt_d       = cnt_q - LEN_W'(1);
        // terminal count: this edge performs the last shift
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register datapath: hold / shift right / shift left / parallel load,
// plus counted shift bursts sequenced by usr_burst_ctrl.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit ROTATE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         sin_r,
  input  logic                         sin_l,
  input  logic [WIDTH-1:0]             pin,
  input  logic                         start,
  input  logic [$clog2(WIDTH+1)-1:0]   len,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_r,
  output logic                         sout_l,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] shr_val, shl_val;
  logic             fill_r, fill_l;
  logic             burst_shift, burst_left, idle_op;

  usr_burst_ctrl #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_burst_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .len         (len),
    .burst_shift (burst_shift),
    .burst_left  (burst_left),
    .idle_op     (idle_op),
    .busy        (busy),
    .done        (done)
  );

  // In rotate mode the outgoing bit recirculates and the serial inputs are unused.
  assign fill_r  = ROTATE ? q_r[0]       : sin_r;
  assign fill_l  = ROTATE ? q_r[WIDTH-1] : sin_l;
  assign shr_val = {fill_r, q_r[WIDTH-1:1]};
  assign shl_val = {q_r[WIDTH-2:0], fill_l};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (burst_shift) begin
      q_r <= burst_left ? shl_val : shr_val;
    end else if (idle_op && en) begin
      case (mode_e'(mode))
        MODE_SHR:  q_r <= shr_val;
        MODE_SHL:  q_r <= shl_val;
        MODE_LOAD: q_r <= pin;
        default:   q_r <= q_r;
      endcase
    end
  end

  assign q      = q_r;
  assign sout_r = q_r[0];
  assign sout_l = q_r[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: plain and rotating instances share stimulus,
// a per-edge reference model plus hand-computed scenario checks.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, sin_r = 1'b0, sin_l = 1'b0, start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  pin = '0;
  logic [LW-1:0] len = '0;

  logic [W-1:0]  q0, q1;
  logic          sr0, sl0, busy0, done0;
  logic          sr1, sl1, busy1, done1;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  logic [W-1:0]  m_q0, m_q1;
  logic [1:0]    m_st;
  logic [LW-1:0] m_rem;
  logic          m_left;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .ROTATE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin), .start(start), .len(len), .q(q0), .sout_r(sr0), .sout_l(sl0),
    .busy(busy0), .done(done0)
  );

  univ_shift_reg #(.WIDTH(W), .ROTATE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin), .start(start), .len(len), .q(q1), .sout_r(sr1), .sout_l(sl1),
    .busy(busy1), .done(done1)
  );

  // Reference model: m_st 0=idle, 1=shift, 2=done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q0 <= '0; m_q1 <= '0; m_st <= 2'd0; m_rem <= '0; m_left <= 1'b0;
    end else begin
      case (m_st)
        2'd0: begin
          if (start && (mode == 2'b01 || mode == 2'b10)) begin
            m_left <= (mode == 2'b10);
            if (len == '0) m_st <= 2'd2;
            else begin
              m_st  <= 2'd1;
              m_rem <= (len > LW'(W)) ? LW'(W) : len;
            end
          end else if (en) begin
            case (mode)
              2'b01: begin m_q0 <= {sin_r, m_q0[W-1:1]}; m_q1 <= {m_q1[0], m_q1[W-1:1]}; end
              2'b10: begin m_q0 <= {m_q0[W-2:0], sin_l}; m_q1 <= {m_q1[W-2:0], m_q1[W-1]}; end
              2'b11: begin m_q0 <= pin; m_q1 <= pin; end
              default: ;
            endcase
          end
        end
        2'd1: begin
          if (m_left) begin
            m_q0 <= {m_q0[W-2:0], sin_l}; m_q1 <= {m_q1[W-2:0], m_q1[W-1]};
          end else begin
            m_q0 <= {sin_r, m_q0[W-1:1]}; m_q1 <= {m_q1[0], m_q1[W-1:1]};
          end
          m_rem <= m_rem - LW'(1);
          if (m_rem == LW'(1)) m_st <= 2'd2;
        end
        default: m_st <= 2'd0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks = checks + 1;
      if ({q0, sr0, sl0, busy0, done0} !== {m_q0, m_q0[0], m_q0[W-1], m_st == 2'd1, m_st == 2'd2}) begin
        failures = failures + 1;
        $display("FAIL mon_plain t=%0t got q=%h sr=%b sl=%b busy=%b done=%b exp q=%h st=%0d",
                 $time, q0, sr0, sl0, busy0, done0, m_q0, m_st);
      end
      checks = checks + 1;
      if ({q1, sr1, sl1, busy1, done1} !== {m_q1, m_q1[0], m_q1[W-1], m_st == 2'd1, m_st == 2'd2}) begin
        failures = failures + 1;
        $display("FAIL mon_rot t=%0t got q=%h sr=%b sl=%b busy=%b done=%b exp q=%h st=%0d",
                 $time, q1, sr1, sl1, busy1, done1, m_q1, m_st);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; start = 1'b0; mode = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    mon_en = 1'b1;
    checks = checks + 1;
    if ({q0, q1, busy0, done0, busy1, done1} !== {16'h0000, 4'b0000}) begin
      failures = failures + 1;
      $display("FAIL reset_state got q0=%h q1=%h b/d=%b%b%b%b exp zeros", q0, q1, busy0, done0, busy1, done1);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_shr();
    mode = 2'b11; pin = 8'hA5; en = 1'b1;
    cyc(1);
    checks = checks + 1;
    if ({q0, q1} !== {8'hA5, 8'hA5}) begin
      failures = failures + 1;
      $display("FAIL load_a5 got q0=%h q1=%h exp a5 a5", q0, q1);
    end
    mode = 2'b01; sin_r = 1'b0;
    cyc(4);
    idle_inputs();
    checks = checks + 1;
    if ({q0, sr0, q1, sr1} !== {8'h0A, 1'b0, 8'h5A, 1'b0}) begin
      failures = failures + 1;
      $display("FAIL shr4 got q0=%h sr0=%b q1=%h sr1=%b exp 0a 0 5a 0", q0, sr0, q1, sr1);
    end
  endtask

  task automatic test_shl();
    mode = 2'b11; pin = 8'h81; en = 1'b1;
    cyc(1);
    mode = 2'b10; sin_l = 1'b1;
    cyc(1);
    idle_inputs();
    checks = checks + 1;
    if ({q0, sl0, q1, sl1} !== {8'h03, 1'b0, 8'h03, 1'b0}) begin
      failures = failures + 1;
      $display("FAIL shl1 got q0=%h sl0=%b q1=%h sl1=%b exp 03 0 03 0", q0, sl0, q1, sl1);
    end
    en = 1'b1; mode = 2'b00;
    cyc(2);
    en = 1'b0; mode = 2'b01;
    cyc(1);
    idle_inputs();
    checks = checks + 1;
    if ({q0, q1} !== {8'h03, 8'h03}) begin
      failures = failures + 1;
      $display("FAIL hold got q0=%h q1=%h exp 03 03", q0, q1);
    end
  endtask

  task automatic test_burst();
    mode = 2'b11; pin = 8'hF0; en = 1'b1;
    cyc(1);
    start = 1'b1; mode = 2'b01; len = 4'd3; sin_r = 1'b0;
    cyc(1);
    checks = checks + 1;
    if ({busy0, done0, q0} !== {1'b1, 1'b0, 8'hF0}) begin
      failures = failures + 1;
      $display("FAIL burst_launch got busy=%b done=%b q=%h exp 1 0 f0", busy0, done0, q0);
    end
    // these must be ignored while shifting
    mode = 2'b11; pin = 8'h00; start = 1'b1; en = 1'b1;
    cyc(1);
    checks = checks + 1;
    if ({busy0, q0} !== {1'b1, 8'h78}) begin
      failures = failures + 1;
      $display("FAIL burst_s1 got busy=%b q=%h exp 1 78", busy0, q0);
    end
    cyc(1);
    checks = checks + 1;
    if ({busy0, q0} !== {1'b1, 8'h3C}) begin
      failures = failures + 1;
      $display("FAIL burst_s2 got busy=%b q=%h exp 1 3c", busy0, q0);
    end
    cyc(1);
    checks = checks + 1;
    if ({busy0, done0, q0, q1} !== {1'b0, 1'b1, 8'h1E, 8'h1E}) begin
      failures = failures + 1;
      $display("FAIL burst_done got busy=%b done=%b q0=%h q1=%h exp 0 1 1e 1e", busy0, done0, q0, q1);
    end
    start = 1'b1; mode = 2'b01; len = 4'd2; en = 1'b0;
    cyc(1);
    idle_inputs();
    checks = checks + 1;
    if ({busy0, done0, q0} !== {1'b0, 1'b0, 8'h1E}) begin
      failures = failures + 1;
      $display("FAIL done_ignores_start got busy=%b done=%b q=%h exp 0 0 1e", busy0, done0, q0);
    end
  endtask

  task automatic test_len0();
    start = 1'b1; mode = 2'b01; len = 4'd0; en = 1'b1; sin_r = 1'b1;
    cyc(1);
    idle_inputs();
    checks = checks + 1;
    if ({busy0, done0, q0, q1} !== {1'b1 ^ 1'b1, 1'b1, 8'h1E, 8'h1E}) begin
      failures = failures + 1;
      $display("FAIL len0_done got busy=%b done=%b q0=%h q1=%h exp 0 1 1e 1e", busy0, done0, q0, q1);
    end
    cyc(1);
    checks = checks + 1;
    if ({busy0, done0} !== 2'b00) begin
      failures = failures + 1;
      $display("FAIL len0_after got busy=%b done=%b exp 0 0", busy0, done0);
    end
    start = 1'b1; mode = 2'b11; pin = 8'hC3; len = 4'd5; en = 1'b1;
    cyc(1);
    idle_inputs();
    checks = checks + 1;
    if ({busy0, done0, q0, q1} !== {2'b00, 8'hC3, 8'hC3}) begin
      failures = failures + 1;
      $display("FAIL start_load got busy=%b done=%b q0=%h q1=%h exp 0 0 c3 c3", busy0, done0, q0, q1);
    end
    cyc(1);
    checks = checks + 1;
    if ({busy0, done0} !== 2'b00) begin
      failures = failures + 1;
      $display("FAIL start_load_nodone got busy=%b done=%b exp 0 0", busy0, done0);
    end
  endtask

  task automatic test_clamp();
    int nb, nd;
    nb = 0; nd = 0;
    mode = 2'b11; pin = 8'h01; en = 1'b1;
    cyc(1);
    start = 1'b1; mode = 2'b10; len = 4'd15; sin_l = 1'b0;
    cyc(1);
    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      if (busy0) nb++;
      if (done0) nd++;
      cyc(1);
    end
    checks = checks + 1;
    if ({nb, nd} !== {32'd8, 32'd1}) begin
      failures = failures + 1;
      $display("FAIL clamp_len got busy_cycles=%0d done_pulses=%0d exp 8 1", nb, nd);
    end
    checks = checks + 1;
    if ({q0, q1} !== {8'h00, 8'h01}) begin
      failures = failures + 1;
      $display("FAIL clamp_q got q0=%h q1=%h exp 00 01", q0, q1);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    nd = 0;
    mode = 2'b11; pin = 8'hFF; en = 1'b1;
    cyc(1);
    start = 1'b1; mode = 2'b10; len = 4'd8; sin_l = 1'b0;
    cyc(1);
    idle_inputs();
    cyc(3);
    checks = checks + 1;
    if ({busy0, q0, q1} !== {1'b1, 8'hF8, 8'hFF}) begin
      failures = failures + 1;
      $display("FAIL mid_burst got busy=%b q0=%h q1=%h exp 1 f8 ff", busy0, q0, q1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({q0, q1, busy0, done0, busy1, done1} !== {16'h0000, 4'b0000}) begin
      failures = failures + 1;
      $display("FAIL async_abort got q0=%h q1=%h b/d=%b%b%b%b exp zeros", q0, q1, busy0, done0, busy1, done1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (done0 || done1) nd++;
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    mode = 2'b11; pin = 8'h3C; en = 1'b1;
    cyc(1);
    idle_inputs();
    checks = checks + 1;
    if ({q0, q1, busy0} !== {8'h3C, 8'h3C, 1'b0}) begin
      failures = failures + 1;
      $display("FAIL reload_3c got q0=%h q1=%h busy=%b exp 3c 3c 0", q0, q1, busy0);
    end
    for (int i = 0; i < 6; i++) begin
      if (done0 || done1) nd++;
      cyc(1);
    end
    checks = checks + 1;
    if (nd !== 0) begin
      failures = failures + 1;
      $display("FAIL abort_no_done got done_pulses=%0d exp 0", nd);
    end
  endtask

  initial begin
    test_reset();
    test_shr();
    test_shl();
    test_burst();
    test_len0();
    test_clamp();
    test_reset_mid();
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
